// File: rtl/control_pipeline_pkg.sv
// Shared encodings and stage bundles for the MIPS control pipeline.
// Forwarding is compiled in with CTRL_FORWARD_EN (see control_pipeline.sv).
package ctrl_pkg;
    localparam int REG_W = 5;
    localparam int ALU_W = 4;

    localparam logic [5:0] OP_RTYPE = 6'h00, OP_J    = 6'h02, OP_BEQ  = 6'h04,
                           OP_BNE   = 6'h05, OP_ADDI = 6'h08, OP_ADDIU = 6'h09,
                           OP_ANDI  = 6'h0c, OP_ORI  = 6'h0d, OP_XORI = 6'h0e,
                           OP_LW    = 6'h23, OP_SW   = 6'h2b;

    localparam logic [5:0] FN_ADD = 6'h20, FN_ADDU = 6'h21, FN_SUB = 6'h22,
                           FN_SUBU = 6'h23, FN_AND = 6'h24, FN_OR = 6'h25,
                           FN_XOR = 6'h26, FN_NOR = 6'h27, FN_SLT = 6'h2a;

    localparam logic [ALU_W-1:0] ALU_AND = 4'b0000, ALU_OR  = 4'b0001, ALU_ADD = 4'b0010,
                                 ALU_SUB = 4'b0110, ALU_SLT = 4'b0111, ALU_NOR = 4'b1100,
                                 ALU_XOR = 4'b1101, ALU_NONE = 4'b1111;

    localparam logic [1:0] BR_NONE = 2'b00, BR_EQ = 2'b01, BR_NE = 2'b10;
    localparam logic [1:0] FWD_RF = 2'b00, FWD_WB = 2'b01, FWD_MEM = 2'b10;

    typedef struct packed {
        logic [ALU_W-1:0] alu_control;
        logic             alu_src;
        logic             reg_dst;
        logic             jump;
        logic [1:0]       branch;
        logic             mem_read;
        logic             mem_write;
        logic             reg_write;
        logic             mem_to_reg;
        logic [REG_W-1:0] rs;
        logic [REG_W-1:0] rt;
        logic [REG_W-1:0] dest;
    } ctrl_t;

    typedef struct packed {
        logic             mem_read;
        logic             mem_write;
        logic             reg_write;
        logic             mem_to_reg;
        logic [REG_W-1:0] dest;
    } mem_ctrl_t;

    typedef struct packed {
        logic             reg_write;
        logic             mem_to_reg;
        logic [REG_W-1:0] dest;
    } wb_ctrl_t;

    function automatic ctrl_t bubble();
        ctrl_t c;
        c = '0;
        c.alu_control = ALU_NONE;
        return c;
    endfunction
endpackage

// File: rtl/control_pipeline_if.sv
// Datapath <-> control pipeline bundle; master is the datapath side.
interface control_pipeline_if #(
    parameter int REG_ADDR_W = 5,
    parameter int ALUCTRL_W  = 4
);
    logic [31:0]           id_instr;
    logic                  id_valid;
    logic                  mem_busy;
    logic                  ex_flush;
    logic                  stall_id;
    logic                  id_illegal;
    logic [ALUCTRL_W-1:0]  ex_alu_control;
    logic                  ex_alu_src;
    logic                  ex_reg_dst;
    logic                  ex_jump;
    logic [1:0]            ex_branch;
    logic [REG_ADDR_W-1:0] ex_rs;
    logic [REG_ADDR_W-1:0] ex_rt;
    logic [REG_ADDR_W-1:0] ex_dest;
    logic [1:0]            forward_a;
    logic [1:0]            forward_b;
    logic                  mem_mem_read;
    logic                  mem_mem_write;
    logic                  mem_reg_write;
    logic [REG_ADDR_W-1:0] mem_dest;
    logic                  wb_reg_write;
    logic                  wb_mem_to_reg;
    logic [REG_ADDR_W-1:0] wb_dest;

    modport master (
        output id_instr, id_valid, mem_busy, ex_flush,
        input  stall_id, id_illegal, ex_alu_control, ex_alu_src, ex_reg_dst, ex_jump,
               ex_branch, ex_rs, ex_rt, ex_dest, forward_a, forward_b, mem_mem_read,
               mem_mem_write, mem_reg_write, mem_dest, wb_reg_write, wb_mem_to_reg, wb_dest
    );

    modport slave (
        input  id_instr, id_valid, mem_busy, ex_flush,
        output stall_id, id_illegal, ex_alu_control, ex_alu_src, ex_reg_dst, ex_jump,
               ex_branch, ex_rs, ex_rt, ex_dest, forward_a, forward_b, mem_mem_read,
               mem_mem_write, mem_reg_write, mem_dest, wb_reg_write, wb_mem_to_reg, wb_dest
    );
endinterface

// File: rtl/control_pipeline_decode.sv
// Combinational instruction decoder: instruction word -> control bundle,
// rt-is-a-source flag and illegal flag. Unsupported or invalid slots decode to a bubble.
module control_decode
    import ctrl_pkg::*;
(
    input  logic [31:0] instr,
    input  logic        valid,
    output ctrl_t       ctrl,
    output logic        rt_src,
    output logic        illegal
);
    logic [5:0]       op, fn;
    logic [REG_W-1:0] rd;
    logic             legal;

    assign op = instr[31:26];
    assign fn = instr[5:0];
    assign rd = instr[15:11];

    wire unused_shamt = ^instr[10:6];

    always_comb begin
        ctrl    = bubble();
        rt_src  = 1'b0;
        legal   = 1'b1;
        ctrl.rs = instr[25:21];
        ctrl.rt = instr[20:16];
        case (op)
            OP_RTYPE: begin
                ctrl.reg_write = 1'b1;
                ctrl.reg_dst   = 1'b1;
                rt_src         = 1'b1;
                case (fn)
                    FN_ADD, FN_ADDU: ctrl.alu_control = ALU_ADD;
                    FN_SUB, FN_SUBU: ctrl.alu_control = ALU_SUB;
                    FN_AND:          ctrl.alu_control = ALU_AND;
                    FN_OR:           ctrl.alu_control = ALU_OR;
                    FN_XOR:          ctrl.alu_control = ALU_XOR;
                    FN_NOR:          ctrl.alu_control = ALU_NOR;
                    FN_SLT:          ctrl.alu_control = ALU_SLT;
                    default:         legal = 1'b0;
                endcase
            end
            OP_ADDI, OP_ADDIU, OP_ANDI, OP_ORI, OP_XORI: begin
                ctrl.alu_src   = 1'b1;
                ctrl.reg_write = 1'b1;
                case (op)
                    OP_ANDI: ctrl.alu_control = ALU_AND;
                    OP_ORI:  ctrl.alu_control = ALU_OR;
                    OP_XORI: ctrl.alu_control = ALU_XOR;
                    default: ctrl.alu_control = ALU_ADD;
                endcase
            end
            OP_LW: begin
                ctrl.mem_read    = 1'b1;
                ctrl.mem_to_reg  = 1'b1;
                ctrl.alu_src     = 1'b1;
                ctrl.reg_write   = 1'b1;
                ctrl.alu_control = ALU_ADD;
            end
            OP_SW: begin
                ctrl.mem_write   = 1'b1;
                ctrl.alu_src     = 1'b1;
                ctrl.alu_control = ALU_ADD;
                rt_src           = 1'b1;
            end
            OP_BEQ, OP_BNE: begin
                ctrl.alu_control = ALU_SUB;
                ctrl.branch      = (op == OP_BEQ) ? BR_EQ : BR_NE;
                rt_src           = 1'b1;
            end
            OP_J: begin
                // rs/rt bits are jump target here; keep them from faking a hazard
                ctrl.jump = 1'b1;
                ctrl.rs   = '0;
                ctrl.rt   = '0;
            end
            default: legal = 1'b0;
        endcase
        ctrl.dest = ctrl.reg_write ? (ctrl.reg_dst ? rd : ctrl.rt) : '0;
        if (!valid || !legal) begin
            ctrl   = bubble();
            rt_src = 1'b0;
        end
        illegal = valid & ~legal;
    end
endmodule

// File: rtl/control_pipeline.sv
// Pipelined control: ID decode, ID/EX, EX/MEM, MEM/WB stage registers, hazard
// stalls, flush and EX forwarding selects. Define CTRL_FORWARD_EN to enable forwarding.
module control_pipeline
    import ctrl_pkg::*;
#(
    parameter int REG_ADDR_W = 5,
    parameter int ALUCTRL_W  = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    control_pipeline_if.slave  bus
);
    ctrl_t     id_ctrl, ex_q;
    mem_ctrl_t mem_q;
    wb_ctrl_t  wb_q;
    logic      id_rt_src, id_illegal_raw;
    logic      load_use, raw_hz, hazard;

    control_decode u_decode (
        .instr   (bus.id_instr),
        .valid   (bus.id_valid),
        .ctrl    (id_ctrl),
        .rt_src  (id_rt_src),
        .illegal (id_illegal_raw)
    );

    function automatic logic src_hit(input logic [REG_W-1:0] d);
        return (d != '0) && ((d == id_ctrl.rs) || (id_rt_src && (d == id_ctrl.rt)));
    endfunction

    // dest is already zero whenever reg_write is low
    assign load_use = ex_q.mem_read && src_hit(ex_q.dest);

`ifdef CTRL_FORWARD_EN
    assign raw_hz = 1'b0;

    function automatic logic [1:0] fwd_sel(input logic [REG_W-1:0] idx);
        if (idx != '0 && mem_q.reg_write && mem_q.dest == idx) return FWD_MEM;
        if (idx != '0 && wb_q.reg_write && wb_q.dest == idx)   return FWD_WB;
        return FWD_RF;
    endfunction

    assign bus.forward_a = fwd_sel(ex_q.rs);
    assign bus.forward_b = fwd_sel(ex_q.rt);
`else
    // register file writes before it reads, so only EX and MEM producers matter
    assign raw_hz = (ex_q.reg_write && src_hit(ex_q.dest)) ||
                    (mem_q.reg_write && src_hit(mem_q.dest));
    assign bus.forward_a = FWD_RF;
    assign bus.forward_b = FWD_RF;
`endif

    assign hazard         = load_use | raw_hz;
    assign bus.stall_id   = rst_n & (bus.mem_busy | (~bus.ex_flush & hazard));
    assign bus.id_illegal = rst_n & id_illegal_raw;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ex_q  <= bubble();
            mem_q <= '0;
            wb_q  <= '0;
        end else if (!bus.mem_busy) begin
            ex_q  <= (bus.ex_flush || hazard) ? bubble() : id_ctrl;
            mem_q <= '{mem_read: ex_q.mem_read, mem_write: ex_q.mem_write,
                       reg_write: ex_q.reg_write, mem_to_reg: ex_q.mem_to_reg,
                       dest: ex_q.dest};
            wb_q  <= '{reg_write: mem_q.reg_write, mem_to_reg: mem_q.mem_to_reg,
                       dest: mem_q.dest};
        end
    end

    assign bus.ex_alu_control = ALUCTRL_W'(ex_q.alu_control);
    assign bus.ex_alu_src     = ex_q.alu_src;
    assign bus.ex_reg_dst     = ex_q.reg_dst;
    assign bus.ex_jump        = ex_q.jump;
    assign bus.ex_branch      = ex_q.branch;
    assign bus.ex_rs          = REG_ADDR_W'(ex_q.rs);
    assign bus.ex_rt          = REG_ADDR_W'(ex_q.rt);
    assign bus.ex_dest        = REG_ADDR_W'(ex_q.dest);
    assign bus.mem_mem_read   = mem_q.mem_read;
    assign bus.mem_mem_write  = mem_q.mem_write;
    assign bus.mem_reg_write  = mem_q.reg_write;
    assign bus.mem_dest       = REG_ADDR_W'(mem_q.dest);
    assign bus.wb_reg_write   = wb_q.reg_write;
    assign bus.wb_mem_to_reg  = wb_q.mem_to_reg;
    assign bus.wb_dest        = REG_ADDR_W'(wb_q.dest);
endmodule

// File: tb/tb_control_pipeline.sv
// Self-checking bench for control_pipeline: directed scenarios plus randomized
// traffic against a mnemonic-level pipeline model.
module tb_control_pipeline;
    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    control_pipeline_if #(.REG_ADDR_W(5), .ALUCTRL_W(4)) bus ();
    control_pipeline #(.REG_ADDR_W(5), .ALUCTRL_W(4)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

    typedef enum int {K_BUB, K_ADD, K_ADDU, K_SUB, K_SUBU, K_AND, K_OR, K_XOR, K_NOR, K_SLT,
                      K_ADDI, K_ADDIU, K_ANDI, K_ORI, K_XORI, K_LW, K_SW, K_BEQ, K_BNE, K_J,
                      K_ILL, K_ILLF} kind_e;
    typedef struct { kind_e k; int rs; int rt; int rd; } ins_t;
    typedef struct {
        bit [3:0] alu; bit alu_src; bit reg_dst; bit jump; bit [1:0] br;
        bit mrd; bit mwr; bit rw; bit m2r; int rs; int rt; int dest; bit rt_src;
    } exp_t;

    exp_t m_ex, m_mem, m_wb;
    ins_t cur;
    bit   cur_v;
    int   checks = 0, passed = 0;

    function automatic ins_t mk(kind_e k, int rs, int rt, int rd);
        ins_t i; i.k = k; i.rs = rs; i.rt = rt; i.rd = rd; return i;
    endfunction

    function automatic exp_t bub();
        exp_t e;
        e.alu = 4'hf; e.alu_src = 0; e.reg_dst = 0; e.jump = 0; e.br = 0; e.mrd = 0;
        e.mwr = 0; e.rw = 0; e.m2r = 0; e.rs = 0; e.rt = 0; e.dest = 0; e.rt_src = 0;
        return e;
    endfunction

    function automatic bit [3:0] alu_of(kind_e k);
        case (k)
            K_AND, K_ANDI:  return 4'b0000;
            K_OR, K_ORI:    return 4'b0001;
            K_SUB, K_SUBU, K_BEQ, K_BNE: return 4'b0110;
            K_SLT:          return 4'b0111;
            K_NOR:          return 4'b1100;
            K_XOR, K_XORI:  return 4'b1101;
            default:        return 4'b0010;
        endcase
    endfunction

    // What the control bundle for a mnemonic should be, straight from the decode table
    function automatic exp_t expect_of(ins_t i, bit v);
        exp_t e = bub();
        if (!v) return e;
        case (i.k)
            K_ADD, K_ADDU, K_SUB, K_SUBU, K_AND, K_OR, K_XOR, K_NOR, K_SLT: begin
                e.alu = alu_of(i.k); e.rw = 1; e.reg_dst = 1; e.rs = i.rs; e.rt = i.rt;
                e.dest = i.rd; e.rt_src = 1;
            end
            K_ADDI, K_ADDIU, K_ANDI, K_ORI, K_XORI: begin
                e.alu = alu_of(i.k); e.alu_src = 1; e.rw = 1; e.rs = i.rs; e.rt = i.rt; e.dest = i.rt;
            end
            K_LW: begin
                e.alu = 4'b0010; e.mrd = 1; e.m2r = 1; e.alu_src = 1; e.rw = 1;
                e.rs = i.rs; e.rt = i.rt; e.dest = i.rt;
            end
            K_SW: begin
                e.alu = 4'b0010; e.mwr = 1; e.alu_src = 1; e.rs = i.rs; e.rt = i.rt; e.rt_src = 1;
            end
            K_BEQ, K_BNE: begin
                e.alu = 4'b0110; e.br = (i.k == K_BEQ) ? 2'b01 : 2'b10;
                e.rs = i.rs; e.rt = i.rt; e.rt_src = 1;
            end
            K_J: e.jump = 1;
            default: ;
        endcase
        return e;
    endfunction

    function automatic bit [31:0] encode(ins_t i);
        bit [31:0] w = $urandom;
        bit [5:0] fn, op;
        case (i.k)
            K_ADD: fn = 6'h20; K_ADDU: fn = 6'h21; K_SUB: fn = 6'h22; K_SUBU: fn = 6'h23;
            K_AND: fn = 6'h24; K_OR: fn = 6'h25; K_XOR: fn = 6'h26; K_NOR: fn = 6'h27;
            K_SLT: fn = 6'h2a; default: fn = 6'h00;
        endcase
        case (i.k)
            K_ADDI: op = 6'h08; K_ADDIU: op = 6'h09; K_ANDI: op = 6'h0c; K_ORI: op = 6'h0d;
            K_XORI: op = 6'h0e; K_LW: op = 6'h23; K_SW: op = 6'h2b; K_BEQ: op = 6'h04;
            K_BNE: op = 6'h05; default: op = 6'h00;
        endcase
        if (i.k >= K_ADD && i.k <= K_SLT || i.k == K_ILLF)
            return {6'h00, 5'(i.rs), 5'(i.rt), 5'(i.rd), 5'(w[4:0]), fn};
        if (i.k >= K_ADDI && i.k <= K_BNE) return {op, 5'(i.rs), 5'(i.rt), w[15:0]};
        if (i.k == K_J)   return {6'h02, w[25:0]};
        if (i.k == K_ILL) return {6'h3f, w[25:0]};
        return w;
    endfunction

    function automatic bit uses(int d, exp_t id);
        return d != 0 && (d == id.rs || (id.rt_src && d == id.rt));
    endfunction

    function automatic bit exp_stall();
        exp_t id = expect_of(cur, cur_v);
        bit h;
        if (!rst_n) return 0;
        if (bus.mem_busy) return 1;
        if (bus.ex_flush) return 0;
        h = m_ex.mrd && uses(m_ex.dest, id);
`ifndef CTRL_FORWARD_EN
        h = h || (m_ex.rw && uses(m_ex.dest, id)) || (m_mem.rw && uses(m_mem.dest, id));
`endif
        return h;
    endfunction

    function automatic bit [1:0] exp_fwd(int idx);
`ifdef CTRL_FORWARD_EN
        if (idx != 0 && m_mem.rw && m_mem.dest == idx) return 2'b10;
        if (idx != 0 && m_wb.rw && m_wb.dest == idx)   return 2'b01;
`endif
        return 2'b00;
    endfunction

    task automatic drive(ins_t i, bit v, bit busy, bit flush);
        cur = i; cur_v = v;
        bus.id_instr = encode(i); bus.id_valid = v; bus.mem_busy = busy; bus.ex_flush = flush;
        #1;
    endtask

    // Step the model with the current inputs and clock the DUT once
    task automatic advance();
        exp_t nex = m_ex, nmem = m_mem, nwb = m_wb;
        if (!rst_n) begin
            nex = bub(); nmem = bub(); nwb = bub();
        end else if (!bus.mem_busy) begin
            nwb = m_mem; nmem = m_ex;
            nex = (bus.ex_flush || exp_stall()) ? bub() : expect_of(cur, cur_v);
        end
        @(posedge clk); #1;
        m_ex = nex; m_mem = nmem; m_wb = nwb;
    endtask

    task automatic drain();
        drive(mk(K_BUB, 0, 0, 0), 0, 0, 0);
        repeat (3) advance();
    endtask

    task automatic test_reset();
        rst_n = 0;
        drive(mk(K_ADD, 9, 10, 8), 1, 0, 0);
        checks++; if (bus.stall_id !== 1'b0) $display("FAIL rst_stall got %b exp 0", bus.stall_id); else passed++;
        advance(); advance();
        drive(mk(K_ILL, 0, 0, 0), 1, 0, 0);
        checks++; if (bus.id_illegal !== 1'b0) $display("FAIL rst_illegal got %b exp 0", bus.id_illegal); else passed++;
        drive(mk(K_ADD, 9, 10, 8), 1, 0, 0);
        rst_n = 1; #1;
        checks++; if (bus.ex_alu_control !== 4'b1111) $display("FAIL rst_alu got %b exp 1111", bus.ex_alu_control); else passed++;
        checks++;
        if ({bus.ex_alu_src, bus.ex_reg_dst, bus.ex_jump, bus.ex_branch, bus.ex_rs, bus.ex_rt, bus.ex_dest,
             bus.mem_mem_read, bus.mem_mem_write, bus.mem_reg_write, bus.mem_dest,
             bus.wb_reg_write, bus.wb_mem_to_reg, bus.wb_dest} !== '0)
            $display("FAIL rst_ctrl got nonzero stage controls exp all 0");
        else passed++;
        checks++; if ({bus.forward_a, bus.forward_b} !== 4'b0) $display("FAIL rst_fwd got %b exp 0000", {bus.forward_a, bus.forward_b}); else passed++;
    endtask

    task automatic test_load_use();
        drain();
        drive(mk(K_LW, 16, 8, 0), 1, 0, 0); advance();
        drive(mk(K_ADD, 8, 10, 9), 1, 0, 0);
        checks++; if (bus.stall_id !== 1'b1) $display("FAIL lu_stall1 got %b exp 1", bus.stall_id); else passed++;
        advance();
`ifdef CTRL_FORWARD_EN
        checks++; if (bus.stall_id !== 1'b0) $display("FAIL lu_release got %b exp 0", bus.stall_id); else passed++;
        advance();
        checks++; if (bus.ex_alu_control !== 4'b0010) $display("FAIL lu_ex_alu got %b exp 0010", bus.ex_alu_control); else passed++;
        checks++; if (bus.forward_a !== 2'b01) $display("FAIL lu_fwd_a got %b exp 01", bus.forward_a); else passed++;
`else
        checks++; if (bus.stall_id !== 1'b1) $display("FAIL lu_stall2 got %b exp 1", bus.stall_id); else passed++;
        advance();
        checks++; if (bus.stall_id !== 1'b0) $display("FAIL lu_release got %b exp 0", bus.stall_id); else passed++;
        advance();
        checks++; if (bus.ex_alu_control !== 4'b0010) $display("FAIL lu_ex_alu got %b exp 0010", bus.ex_alu_control); else passed++;
        checks++; if (bus.forward_a !== 2'b00) $display("FAIL lu_fwd_a got %b exp 00", bus.forward_a); else passed++;
`endif
    endtask

    task automatic test_raw();
        drain();
        drive(mk(K_ADD, 9, 10, 8), 1, 0, 0); advance();
        drive(mk(K_SUB, 8, 8, 11), 1, 0, 0);
`ifdef CTRL_FORWARD_EN
        checks++; if (bus.stall_id !== 1'b0) $display("FAIL raw_nostall got %b exp 0", bus.stall_id); else passed++;
        advance();
        checks++; if ({bus.forward_a, bus.forward_b} !== 4'b1010) $display("FAIL raw_fwd got %b exp 1010", {bus.forward_a, bus.forward_b}); else passed++;
`else
        checks++; if (bus.stall_id !== 1'b1) $display("FAIL raw_stall1 got %b exp 1", bus.stall_id); else passed++;
        advance();
        checks++; if (bus.stall_id !== 1'b1) $display("FAIL raw_stall2 got %b exp 1", bus.stall_id); else passed++;
        advance();
        checks++; if (bus.stall_id !== 1'b0) $display("FAIL raw_release got %b exp 0", bus.stall_id); else passed++;
        advance();
        checks++; if ({bus.forward_a, bus.forward_b} !== 4'b0000) $display("FAIL raw_fwd got %b exp 0000", {bus.forward_a, bus.forward_b}); else passed++;
`endif
        checks++; if (bus.ex_alu_control !== 4'b0110) $display("FAIL raw_ex_alu got %b exp 0110", bus.ex_alu_control); else passed++;
    endtask

    task automatic test_flush_busy();
        drain();
        drive(mk(K_ORI, 9, 8, 0), 1, 0, 1);
        checks++; if (bus.stall_id !== 1'b0) $display("FAIL fl_stall got %b exp 0", bus.stall_id); else passed++;
        advance();
        checks++; if ({bus.ex_alu_control, bus.ex_dest, bus.ex_alu_src} !== 10'b1111_00000_0)
            $display("FAIL fl_bubble got %b exp 1111000000", {bus.ex_alu_control, bus.ex_dest, bus.ex_alu_src}); else passed++;
        drive(mk(K_ADD, 9, 10, 8), 1, 0, 0); advance();
        drive(mk(K_ORI, 9, 12, 0), 1, 1, 1);
        checks++; if (bus.stall_id !== 1'b1) $display("FAIL busy_stall got %b exp 1", bus.stall_id); else passed++;
        advance();
        checks++; if ({bus.ex_alu_control, bus.ex_dest} !== {4'b0010, 5'd8})
            $display("FAIL busy_hold got %b exp 001001000", {bus.ex_alu_control, bus.ex_dest}); else passed++;
        advance(); advance();
        checks++; if ({bus.ex_dest, bus.mem_reg_write} !== {5'd8, 1'b0})
            $display("FAIL busy_hold3 got %b exp 010000", {bus.ex_dest, bus.mem_reg_write}); else passed++;
        bus.mem_busy = 0; #1;
        checks++; if (bus.stall_id !== 1'b0) $display("FAIL unbusy_stall got %b exp 0", bus.stall_id); else passed++;
        advance();
        checks++; if ({bus.ex_alu_control, bus.mem_reg_write, bus.mem_dest} !== {4'b1111, 1'b1, 5'd8})
            $display("FAIL busy_then_flush got %b exp 1111101000", {bus.ex_alu_control, bus.mem_reg_write, bus.mem_dest}); else passed++;
        drive(mk(K_ADD, 9, 10, 8), 1, 1, 0);
        rst_n = 0; #1;
        checks++; if (bus.stall_id !== 1'b0) $display("FAIL rst_busy_stall got %b exp 0", bus.stall_id); else passed++;
        advance();
        checks++; if ({bus.mem_dest, bus.wb_dest, bus.ex_alu_control} !== {10'd0, 4'b1111})
            $display("FAIL rst_busy_clear got %b exp 00000000001111", {bus.mem_dest, bus.wb_dest, bus.ex_alu_control}); else passed++;
        rst_n = 1;
    endtask

    task automatic test_illegal_zero();
        drain();
        drive(mk(K_ILL, 0, 0, 0), 1, 0, 0);
        checks++; if (bus.id_illegal !== 1'b1) $display("FAIL ill_op got %b exp 1", bus.id_illegal); else passed++;
        advance();
        checks++; if ({bus.ex_alu_control, bus.ex_rs, bus.ex_rt, bus.ex_jump} !== {4'b1111, 11'd0})
            $display("FAIL ill_bubble got %b exp 111100000000000", {bus.ex_alu_control, bus.ex_rs, bus.ex_rt, bus.ex_jump}); else passed++;
        drive(mk(K_ILL, 0, 0, 0), 0, 0, 0);
        checks++; if (bus.id_illegal !== 1'b0) $display("FAIL ill_invalid got %b exp 0", bus.id_illegal); else passed++;
        drive(mk(K_ILLF, 3, 4, 5), 1, 0, 0);
        checks++; if (bus.id_illegal !== 1'b1) $display("FAIL ill_funct got %b exp 1", bus.id_illegal); else passed++;
        drive(mk(K_ADD, 9, 10, 0), 1, 0, 0); advance();
        drive(mk(K_ADD, 0, 0, 8), 1, 0, 0);
        checks++; if ({bus.stall_id, bus.ex_dest} !== 6'd0) $display("FAIL zero_nostall got %b exp 000000", {bus.stall_id, bus.ex_dest}); else passed++;
        advance();
        checks++; if ({bus.forward_a, bus.forward_b} !== 4'b0) $display("FAIL zero_fwd got %b exp 0000", {bus.forward_a, bus.forward_b}); else passed++;
        drive(mk(K_LW, 9, 0, 0), 1, 0, 0); advance();
        drive(mk(K_ADD, 0, 0, 8), 1, 0, 0);
        checks++; if (bus.stall_id !== 1'b0) $display("FAIL zero_lu got %b exp 0", bus.stall_id); else passed++;
    endtask

    task automatic test_random();
        bit [5:0]  o_c, e_c;
        bit [23:0] o_x, e_x;
        bit [14:0] o_m, e_m;
        drain();
        for (int n = 0; n < 600; n++) begin
            rst_n = ($urandom_range(0, 99) >= 2);
            drive(mk(kind_e'($urandom_range(int'(K_ADD), int'(K_ILLF))), $urandom_range(0, 3),
                     $urandom_range(0, 3), $urandom_range(0, 3)),
                  $urandom_range(0, 9) != 0, $urandom_range(0, 99) < 15, $urandom_range(0, 99) < 10);
            o_c = {bus.stall_id, bus.id_illegal, bus.forward_a, bus.forward_b};
            e_c = {exp_stall(), rst_n && cur_v && (cur.k == K_ILL || cur.k == K_ILLF),
                   exp_fwd(m_ex.rs), exp_fwd(m_ex.rt)};
            checks++; if (o_c !== e_c) $display("FAIL rnd_comb[%0d] got %b exp %b", n, o_c, e_c); else passed++;
            o_x = {bus.ex_alu_control, bus.ex_alu_src, bus.ex_reg_dst, bus.ex_jump, bus.ex_branch,
                   bus.ex_rs, bus.ex_rt, bus.ex_dest};
            e_x = {m_ex.alu, m_ex.alu_src, m_ex.reg_dst, m_ex.jump, m_ex.br,
                   5'(m_ex.rs), 5'(m_ex.rt), 5'(m_ex.dest)};
            checks++; if (o_x !== e_x) $display("FAIL rnd_ex[%0d] got %h exp %h", n, o_x, e_x); else passed++;
            o_m = {bus.mem_mem_read, bus.mem_mem_write, bus.mem_reg_write, bus.mem_dest,
                   bus.wb_reg_write, bus.wb_mem_to_reg, bus.wb_dest};
            e_m = {m_mem.mrd, m_mem.mwr, m_mem.rw, 5'(m_mem.dest), m_wb.rw, m_wb.m2r, 5'(m_wb.dest)};
            checks++; if (o_m !== e_m) $display("FAIL rnd_memwb[%0d] got %h exp %h", n, o_m, e_m); else passed++;
            advance();
        end
        rst_n = 1;
    endtask

    initial begin
        m_ex = bub(); m_mem = bub(); m_wb = bub();
        test_reset();
        test_load_use();
        test_raw();
        test_flush_busy();
        test_illegal_zero();
        test_random();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end
endmodule
